// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed common-anode 7-segment scanner with a frame-coherent shadow copy.
// Optional LEADING_ZERO_BLANK_EN: suppress leading-zero digits (digit 0 always lit).
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              digit_data,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);
    localparam int CMAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d, shadow_q, shadow_d;
    logic [3:0]              digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_done_q, slot_end, boundary, suppress;

    // Output registers are loaded from next-state values so they line up with the state they describe.
    always_comb begin
        slot_end  = state_q == SHOW ? cnt_q == SHOW_LAST : (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST);
        boundary  = state_q == SHOW && slot_end && idx_q == IDX_LAST;
        state_d   = slot_end ? ((state_q == BLANK || BLANK_CYCLES == 0) ? SHOW : BLANK) : state_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = (state_q == SHOW && slot_end) ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        pending_d = load ? value_in : pending_q;
        shadow_d  = boundary ? pending_d : shadow_q;
`ifdef LEADING_ZERO_BLANK_EN
        suppress  = idx_d != '0 && (shadow_d >> {idx_d, 2'b00}) == '0;
`else
        suppress  = 1'b0;
`endif
        digit_d   = suppress ? 4'hF : 4'(shadow_d >> {idx_d, 2'b00});
        anode_d   = (state_d == SHOW && !suppress) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            digit_q      <= 4'hF;
            anode_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            digit_q      <= digit_d;
            anode_q      <= anode_d;
            frame_done_q <= boundary;
        end
    end

    assign digit_data = digit_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: randomized scoreboard bench; expectations derived from cycle position within the frame.
module tb_sevenseg_scan_ctrl;
    localparam int N = 4, RD = 4, BC = 2, SLOT = BC + RD, FRAME = N * SLOT;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  digit_data, anode;
    logic        frame_done;

    typedef struct packed {
        logic [31:0] t;
        logic [3:0]  an;
        logic [3:0]  dd;
        logic        fd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0, t = 0;
    logic [15:0] shadow_m = '0, pending_m = '0;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load),
        .digit_data(digit_data), .anode(anode), .frame_done(frame_done)
    );

    // Cycle 0 after reset release still shows reset values; from cycle 1 the frame position is t mod FRAME.
    function automatic exp_t model(int tt, logic [15:0] sh, bit in_rst);
        exp_t        e;
        int          pos, d;
        bit          show, sup;
        logic [15:0] upper;
        e = '{t: 32'(tt), an: 4'hF, dd: 4'hF, fd: 1'b0};
        if (in_rst || tt == 0) return e;
        pos   = tt % FRAME;
        d     = pos / SLOT;
        show  = (pos % SLOT) >= BC;
        upper = sh >> (4 * d);
        sup   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        sup   = d > 0 && upper == 0;
`endif
        e.fd = pos == 0;
        e.dd = sup ? 4'hF : upper[3:0];
        if (show && !sup) e.an = 4'hF ^ 4'(1 << d);
        return e;
    endfunction

    task automatic step(input bit ld, input logic [15:0] v);
        q.push_back(model(t, shadow_m, 1'b0));
        load     = ld;
        value_in = v;
        if (t % FRAME == FRAME - 1) shadow_m = ld ? v : pending_m;
        if (ld) pending_m = v;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic reset_pulse();
        load = 1'b0;
        rst  = 1'b1;
        repeat (2) begin
            q.push_back(model(t, shadow_m, 1'b1));
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        t         = 0;
        shadow_m  = '0;
        pending_m = '0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (anode !== e.an || digit_data !== e.dd || frame_done !== e.fd) begin
                errors++;
                $display("FAIL scan t=%0d: anode=%b data=%h fd=%b, required anode=%b data=%h fd=%b",
                         e.t, anode, digit_data, frame_done, e.an, e.dd, e.fd);
            end
            checks++;
            if ($countones(~anode) > 1) begin
                errors++;
                $display("FAIL anode_onehot t=%0d: anode=%b, required at most one low bit", e.t, anode);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        reset_pulse();
        for (int i = 0; i < 48; i++) step(i == 5, 16'h1234);
        for (int i = 0; i < 48; i++) step(i == 10, 16'h5678);
        for (int i = 0; i < 30; i++) step(i == 4 || i == 23, i == 23 ? 16'h9999 : 16'h1111);
        repeat (400) step($urandom_range(7) == 0, 16'($urandom) >> (4 * $urandom_range(4)));
        while (t % FRAME != 15) step(1'b0, 16'h0);
        reset_pulse();
        for (int i = 0; i < 48; i++) step(i == 5, 16'h0050);
        for (int i = 0; i < 48; i++) step(i == 3, 16'h0000);
        repeat (100) step($urandom_range(3) == 0, 16'($urandom) >> (4 * $urandom_range(4)));
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
